// File: rtl/sumatoria.sv
// sumatoria: combinational nibble sum with a registered sample and saturating accumulator
module sumatoria #(
  parameter int NIB_W = 4,
  parameter int NIB_N = 4,
  parameter int ACC_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NIB_N*NIB_W-1:0]           Input,
  output logic [NIB_W+$clog2(NIB_N)-1:0]   Output,
  input  logic                             In_valid,
  input  logic                             Acc_clr,
  output logic [NIB_W+$clog2(NIB_N)-1:0]   Sum_q,
  output logic                             Out_valid,
  output logic [ACC_W-1:0]                 Acc,
  output logic                             Acc_sat
);
  localparam int OUT_W = NIB_W + $clog2(NIB_N);
  logic [ACC_W:0] acc_nxt;
  always_comb begin
    Output = '0;
    for (int k = 0; k < NIB_N; k++) Output = Output + OUT_W'(Input[k*NIB_W +: NIB_W]);
  end
  // one extra bit catches the carry that signals saturation
  assign acc_nxt = {1'b0, Acc} + (ACC_W+1)'(Output);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sum_q <= '0;
      Out_valid <= 1'b0;
      Acc <= '0;
      Acc_sat <= 1'b0;
    end else begin
      Out_valid <= In_valid;
      if (In_valid) Sum_q <= Output;
      if (Acc_clr) begin
        Acc <= '0;
        Acc_sat <= 1'b0;
      end else if (In_valid) begin
        Acc <= acc_nxt[ACC_W] ? '1 : acc_nxt[ACC_W-1:0];
        if (acc_nxt[ACC_W]) Acc_sat <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sumatoria.sv
// tb_sumatoria: directed scoreboard bench for sumatoria
module tb_sumatoria;
  logic clk = 0, rst_n, In_valid, Acc_clr;
  logic [15:0] Input, Acc;
  logic [5:0] Output, Sum_q;
  logic Out_valid, Acc_sat;
  int checks = 0, errors = 0;
  logic [5:0] q[$];
  logic [5:0] m_sum;
  logic [15:0] m_acc;
  logic m_sat;

  sumatoria dut (
    .clk(clk), .rst_n(rst_n), .Input(Input), .Output(Output), .In_valid(In_valid),
    .Acc_clr(Acc_clr), .Sum_q(Sum_q), .Out_valid(Out_valid), .Acc(Acc), .Acc_sat(Acc_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [5:0] ref_sum(input logic [15:0] d);
    return 6'(d[15:12]) + 6'(d[11:8]) + 6'(d[7:4]) + 6'(d[3:0]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic clr, input logic r, input logic [15:0] d);
    logic [16:0] t;
    In_valid = v; Acc_clr = clr; rst_n = r; Input = d;
    #1 chk("output", 32'(Output), 32'(ref_sum(d)));
    if (!r) begin
      q.delete(); m_sum = 0; m_acc = 0; m_sat = 0;
    end else begin
      if (v) q.push_back(ref_sum(d));
      if (clr) begin
        m_acc = 0; m_sat = 0;
      end else if (v) begin
        t = {1'b0, m_acc} + 17'(ref_sum(d));
        if (t > 17'd65535) begin m_acc = 16'hFFFF; m_sat = 1; end
        else m_acc = t[15:0];
      end
    end
    @(posedge clk); #1;
    chk("out_valid", 32'(Out_valid), 32'(r && v));
    if (r && v) m_sum = q.pop_front();
    chk("sum_q", 32'(Sum_q), 32'(m_sum));
    chk("acc", 32'(Acc), 32'(m_acc));
    chk("acc_sat", 32'(Acc_sat), 32'(m_sat));
  endtask

  initial begin
    rst_n = 0; In_valid = 0; Acc_clr = 0;
    Input = 16'h5326; #2 chk("comb_5326", 32'(Output), 32'd16);
    Input = 16'h2146; #0.5 chk("comb_2146", 32'(Output), 32'd13);
    Input = 16'h5176; #0.5 chk("comb_5176", 32'(Output), 32'd19);
    Input = 16'h0000; #0.5 chk("comb_0000", 32'(Output), 32'd0);
    Input = 16'hFFFF; #0.5 chk("comb_ffff", 32'(Output), 32'd60);
    step(1, 1, 0, 16'hFFFF);
    step(0, 0, 0, 16'h0000);
    step(1, 0, 1, 16'h5326);
    step(1, 0, 1, 16'h2146);
    step(1, 0, 1, 16'h5176);
    chk("acc_48", 32'(Acc), 32'd48);
    step(0, 0, 1, 16'h9999);
    chk("hold_19", 32'(Sum_q), 32'd19);
    step(1, 1, 1, 16'h5326);
    chk("clr_acc", 32'(Acc), 32'd0);
    chk("clr_sum", 32'(Sum_q), 32'd16);
    for (int i = 0; i < 1093; i++) step(1, 0, 1, 16'hFFFF);
    chk("sat_acc", 32'(Acc), 32'd65535);
    chk("sat_flag", 32'(Acc_sat), 32'd1);
    step(1, 0, 1, 16'h1111);
    chk("sat_hold", 32'(Acc), 32'd65535);
    step(0, 0, 1, 16'h0000);
    chk("sat_sticky", 32'(Acc_sat), 32'd1);
    step(1, 1, 1, 16'h5326);
    chk("clr_sat", 32'(Acc_sat), 32'd0);
    chk("clr_valid", 32'(Out_valid), 32'd1);
    step(1, 0, 1, 16'hA5C3);
    step(1, 0, 1, 16'h0F0F);
    step(1, 0, 0, 16'h7777);
    chk("mid_rst_valid", 32'(Out_valid), 32'd0);
    chk("mid_rst_acc", 32'(Acc), 32'd0);
    chk("mid_rst_sum", 32'(Sum_q), 32'd0);
    step(1, 0, 1, 16'h1234);
    step(0, 0, 1, 16'h8421);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
